// File: rtl/blink_sequencer_if.sv
// ============================================================================
// Module   : blink_sequencer_if
// Brief    : Command handshake and LED status bundle for blink_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface blink_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] leds;
  logic [1:0] state;
  logic       busy;
  logic       step_pulse;
  logic       done;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, leds, state, busy, step_pulse, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, leds, state, busy, step_pulse, done
  );
endinterface

`default_nettype wire

// File: rtl/blink_sequencer.sv
// ============================================================================
// Module   : blink_sequencer
// Brief    : Command-driven LED pattern engine with prescaler and burst FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blink_sequencer #(
  parameter int CLK_DIV = 25000000,
  parameter int DIV_W   = 25
) (
  input wire logic          clk,
  input wire logic          rst,
  blink_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    BURST  = 2'd2
  } state_t;

  localparam logic [1:0]       C_OP_SET_MODE  = 2'd0;
  localparam logic [1:0]       C_OP_SET_SPEED = 2'd1;
  localparam logic [1:0]       C_OP_LOAD      = 2'd2;
  localparam logic [1:0]       C_OP_CTRL      = 2'd3;
  localparam logic [1:0]       C_MODE_UP      = 2'd0;
  localparam logic [1:0]       C_MODE_DOWN    = 2'd1;
  localparam logic [1:0]       C_MODE_SCAN    = 2'd2;
  localparam logic             C_DIR_LEFT     = 1'b0;
  localparam logic             C_DIR_RIGHT    = 1'b1;
  localparam logic [DIV_W-1:0] C_TICK_MAX     = DIV_W'(CLK_DIV - 1);

  state_t           r_state,      w_state_nxt;
  logic [1:0]       r_mode,       w_mode_nxt;
  logic [3:0]       r_speed,      w_speed_nxt;
  logic [DIV_W-1:0] r_base_cnt,   w_base_cnt_nxt;
  logic [3:0]       r_step_cnt,   w_step_cnt_nxt;
  logic [7:0]       r_leds,       w_leds_nxt;
  logic [7:0]       r_bin,        w_bin_nxt;
  logic             r_dir,        w_dir_nxt;
  logic [7:0]       r_remaining,  w_remaining_nxt;
  logic             r_cmd_ready,  w_cmd_ready_nxt;
  logic             r_step_pulse, w_step_pulse_nxt;
  logic             r_done,       w_done_nxt;

  logic       w_accept;
  logic       w_tick;
  logic       w_step;
  logic       w_onehot;
  logic [7:0] w_bin_inc;

  assign w_accept  = bus.cmd_valid && r_cmd_ready;
  assign w_tick    = (r_state != PAUSED) && (r_base_cnt == C_TICK_MAX);
  assign w_step    = w_tick && (r_step_cnt == r_speed);
  assign w_onehot  = (r_leds != 8'd0) && ((r_leds & (r_leds - 8'd1)) == 8'd0);
  assign w_bin_inc = r_bin + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= PAUSED;
      r_mode       <= C_MODE_UP;
      r_speed      <= 4'd0;
      r_base_cnt   <= '0;
      r_step_cnt   <= 4'd0;
      r_leds       <= 8'h00;
      r_bin        <= 8'h00;
      r_dir        <= C_DIR_LEFT;
      r_remaining  <= 8'd0;
      r_cmd_ready  <= 1'b1;
      r_step_pulse <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_speed      <= w_speed_nxt;
      r_base_cnt   <= w_base_cnt_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_leds       <= w_leds_nxt;
      r_bin        <= w_bin_nxt;
      r_dir        <= w_dir_nxt;
      r_remaining  <= w_remaining_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_step_pulse <= w_step_pulse_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Step effects are computed first from pre-edge registers; commands then override.
  always_comb begin
    w_state_nxt      = r_state;
    w_mode_nxt       = r_mode;
    w_speed_nxt      = r_speed;
    w_base_cnt_nxt   = r_base_cnt;
    w_step_cnt_nxt   = r_step_cnt;
    w_leds_nxt       = r_leds;
    w_bin_nxt        = r_bin;
    w_dir_nxt        = r_dir;
    w_remaining_nxt  = r_remaining;
    w_cmd_ready_nxt  = !w_accept;
    w_step_pulse_nxt = w_step;
    w_done_nxt       = 1'b0;

    if (r_state == PAUSED) begin
      w_base_cnt_nxt = '0;
      w_step_cnt_nxt = 4'd0;
    end else if (w_tick) begin
      w_base_cnt_nxt = '0;
      w_step_cnt_nxt = w_step ? 4'd0 : r_step_cnt + 4'd1;
    end else begin
      w_base_cnt_nxt = r_base_cnt + DIV_W'(1);
    end

    if (w_step) begin
      case (r_mode)
        C_MODE_UP:   w_leds_nxt = r_leds + 8'd1;
        C_MODE_DOWN: w_leds_nxt = r_leds - 8'd1;
        C_MODE_SCAN: begin
          if (!w_onehot) begin
            w_leds_nxt = 8'h01;
            w_dir_nxt  = C_DIR_LEFT;
          end else if (r_leds == 8'h80) begin
            w_leds_nxt = 8'h40;
            w_dir_nxt  = C_DIR_RIGHT;
          end else if (r_leds == 8'h01) begin
            w_leds_nxt = 8'h02;
            w_dir_nxt  = C_DIR_LEFT;
          end else begin
            w_leds_nxt = (r_dir == C_DIR_LEFT) ? (r_leds << 1) : (r_leds >> 1);
          end
        end
        default: begin
          w_bin_nxt  = w_bin_inc;
          w_leds_nxt = w_bin_inc ^ (w_bin_inc >> 1);
        end
      endcase

      if (r_state == BURST) begin
        w_remaining_nxt = r_remaining - 8'd1;
        if (r_remaining == 8'd1) begin
          w_state_nxt = PAUSED;
          w_done_nxt  = 1'b1;
        end
      end
    end

    if (w_accept) begin
      case (bus.cmd_op)
        C_OP_SET_MODE:  w_mode_nxt = bus.cmd_arg[1:0];
        C_OP_SET_SPEED: begin
          w_speed_nxt    = bus.cmd_arg[3:0];
          w_step_cnt_nxt = 4'd0;
        end
        C_OP_LOAD: begin
          w_leds_nxt = bus.cmd_arg;
          w_bin_nxt  = bus.cmd_arg;
        end
        default: begin
          w_done_nxt     = 1'b0;
          w_base_cnt_nxt = '0;
          w_step_cnt_nxt = 4'd0;
          if (bus.cmd_arg == 8'h00) begin
            w_state_nxt = PAUSED;
          end else if (bus.cmd_arg == 8'hFF) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt     = BURST;
            w_remaining_nxt = bus.cmd_arg;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.leds       = r_leds;
  assign bus.state      = r_state;
  assign bus.busy       = (r_state != PAUSED);
  assign bus.step_pulse = r_step_pulse;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_blink_sequencer.sv
// ============================================================================
// Module   : tb_blink_sequencer
// Brief    : Scoreboard bench for blink_sequencer with CLK_DIV=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_blink_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  blink_sequencer_if bus();

  blink_sequencer #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         cyc          = 0;
  logic [7:0] exp_q[$];

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    int w;
    w = 0;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && w < 10) begin
      @(posedge clk); #1; w++;
    end
    n_compared++;
    if (w >= 10) begin n_mismatched++; $display("FAIL ready_timeout: ready=%b want 1", bus.cmd_ready); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    n_compared++;
    if (bus.cmd_ready !== 1'b0) begin n_mismatched++; $display("FAIL ready_low: got %b want 0", bus.cmd_ready); end
    @(posedge clk); #1;
    cyc = 1;
    n_compared++;
    if (bus.cmd_ready !== 1'b1) begin n_mismatched++; $display("FAIL ready_high: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic wait_step(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1; cyc++;
      if (bus.step_pulse === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if (bus.leds !== 8'h00 || bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.step_pulse !== 1'b0 || bus.done !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_state: leds=%h st=%0d busy=%b rdy=%b sp=%b done=%b want 00 0 0 1 0 0",
               bus.leds, bus.state, bus.busy, bus.cmd_ready, bus.step_pulse, bus.done);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_run();
    bit ok; int prev; logic [7:0] e;
    send_cmd(2'd3, 8'hFF);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_step(12, ok);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      n_compared++;
      if (!ok || bus.leds !== e) begin n_mismatched++; $display("FAIL run_leds[%0d]: got %h want %h", i, bus.leds, e); end
      n_compared++;
      if (cyc - prev !== 4) begin n_mismatched++; $display("FAIL run_period[%0d]: got %0d want 4", i, cyc - prev); end
      prev = cyc;
    end
    n_compared++;
    if (bus.busy !== 1'b1 || bus.state !== 2'd1) begin
      n_mismatched++; $display("FAIL run_status: busy=%b st=%0d want 1 1", bus.busy, bus.state);
    end
    send_cmd(2'd3, 8'h00);
  endtask

  task automatic test_wrap_down();
    bit ok; int prev; logic [7:0] e;
    send_cmd(2'd2, 8'hFE);
    send_cmd(2'd0, 8'h00);
    send_cmd(2'd1, 8'h01);
    send_cmd(2'd3, 8'hFF);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    prev = 0;
    for (int i = 0; i < 2; i++) begin
      wait_step(20, ok);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      n_compared++;
      if (!ok || bus.leds !== e) begin n_mismatched++; $display("FAIL wrap_leds[%0d]: got %h want %h", i, bus.leds, e); end
      n_compared++;
      if (cyc - prev !== 8) begin n_mismatched++; $display("FAIL wrap_period[%0d]: got %0d want 8", i, cyc - prev); end
      prev = cyc;
    end
    send_cmd(2'd0, 8'h01);
    exp_q.push_back(8'hFF);
    wait_step(20, ok);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    n_compared++;
    if (!ok || bus.leds !== e) begin n_mismatched++; $display("FAIL down_wrap: got %h want %h", bus.leds, e); end
    send_cmd(2'd3, 8'h00);
  endtask

  task automatic test_scan();
    bit ok; logic [7:0] e;
    logic [7:0] seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    send_cmd(2'd1, 8'h00);
    send_cmd(2'd0, 8'h02);
    send_cmd(2'd2, 8'h03);
    send_cmd(2'd3, 8'hFF);
    foreach (seq[k]) exp_q.push_back(seq[k]);
    for (int i = 0; i < 16; i++) begin
      wait_step(12, ok);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      n_compared++;
      if (!ok || bus.leds !== e) begin n_mismatched++; $display("FAIL scan_leds[%0d]: got %h want %h", i, bus.leds, e); end
    end
    send_cmd(2'd3, 8'h00);
  endtask

  task automatic test_gray_burst();
    bit ok; int steps; logic [7:0] e;
    send_cmd(2'd2, 8'h00);
    send_cmd(2'd0, 8'h03);
    send_cmd(2'd3, 8'h03);
    exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h02);
    for (int i = 0; i < 3; i++) begin
      wait_step(12, ok);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      n_compared++;
      if (!ok || bus.leds !== e) begin n_mismatched++; $display("FAIL gray_leds[%0d]: got %h want %h", i, bus.leds, e); end
      n_compared++;
      if (bus.done !== (i == 2)) begin n_mismatched++; $display("FAIL gray_done[%0d]: got %b want %b", i, bus.done, (i == 2)); end
    end
    n_compared++;
    if (bus.state !== 2'd0 || bus.busy !== 1'b0) begin
      n_mismatched++; $display("FAIL burst_end: st=%0d busy=%b want 0 0", bus.state, bus.busy);
    end
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.step_pulse === 1'b1 || bus.done === 1'b1) steps++;
    end
    n_compared++;
    if (steps !== 0 || bus.leds !== 8'h02) begin
      n_mismatched++; $display("FAIL burst_hold: pulses=%0d leds=%h want 0 02", steps, bus.leds);
    end
  endtask

  task automatic test_ctrl_override();
    bit ok; int steps;
    send_cmd(2'd0, 8'h00);
    send_cmd(2'd2, 8'h10);
    send_cmd(2'd3, 8'h05);
    wait_step(12, ok);
    n_compared++;
    if (!ok || bus.leds !== 8'h11 || cyc !== 4) begin
      n_mismatched++; $display("FAIL ovr_step1: leds=%h cyc=%0d want 11 4", bus.leds, cyc);
    end
    repeat (3) begin @(posedge clk); #1; end
    bus.cmd_op = 2'd3; bus.cmd_arg = 8'h00; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n_compared++;
    if (bus.step_pulse !== 1'b1 || bus.leds !== 8'h12 || bus.done !== 1'b0 || bus.state !== 2'd0 || bus.cmd_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL ovr_edge: sp=%b leds=%h done=%b st=%0d rdy=%b want 1 12 0 0 0",
               bus.step_pulse, bus.leds, bus.done, bus.state, bus.cmd_ready);
    end
    @(posedge clk); #1;
    n_compared++;
    if (bus.cmd_ready !== 1'b1) begin n_mismatched++; $display("FAIL ovr_ready: got %b want 1", bus.cmd_ready); end
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.step_pulse === 1'b1 || bus.done === 1'b1) steps++;
    end
    n_compared++;
    if (steps !== 0 || bus.leds !== 8'h12) begin
      n_mismatched++; $display("FAIL ovr_paused: pulses=%0d leds=%h want 0 12", steps, bus.leds);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok; int steps;
    send_cmd(2'd3, 8'h07);
    wait_step(12, ok);
    n_compared++;
    if (!ok || bus.leds !== 8'h13) begin n_mismatched++; $display("FAIL rb_step: got %h want 13", bus.leds); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_compared++;
    if (bus.leds !== 8'h00 || bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.step_pulse !== 1'b0 || bus.done !== 1'b0) begin
      n_mismatched++;
      $display("FAIL rb_async: leds=%h st=%0d busy=%b rdy=%b sp=%b done=%b want 00 0 0 1 0 0",
               bus.leds, bus.state, bus.busy, bus.cmd_ready, bus.step_pulse, bus.done);
    end
    @(negedge clk) rst = 1'b0;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.step_pulse === 1'b1 || bus.done === 1'b1) steps++;
    end
    n_compared++;
    if (steps !== 0 || bus.leds !== 8'h00) begin
      n_mismatched++; $display("FAIL rb_idle: pulses=%0d leds=%h want 0 00", steps, bus.leds);
    end
    send_cmd(2'd3, 8'hFF);
    wait_step(12, ok);
    n_compared++;
    if (!ok || bus.leds !== 8'h01 || cyc !== 4) begin
      n_mismatched++; $display("FAIL rb_restart: leds=%h cyc=%0d want 01 4", bus.leds, cyc);
    end
    send_cmd(2'd3, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_arg   = 8'h00;
    test_reset();
    test_run();
    test_wrap_down();
    test_scan();
    test_gray_burst();
    test_ctrl_override();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
